// File: rtl/sm4_rkey_sched_if.sv
// sm4_rkey_sched_if
// Bundles the three links that sm4_rkey_sched arbitrates.
//   key load  : key_load_req/key_load_key in, key_load_ack out
//   expansion : kexp_start/kexp_key/kexp_key_vld out, kexp_rkey/kexp_rkey_vld in
//   core      : core_blk_req/core_blk_dec in,
//               core_blk_gnt/core_rkey/core_rkey_vld/core_rkey_idx out
//   status    : keys_ready out
// Modport master is the scheduler. Modport slave is the surrounding key
// source, expansion unit and round core.
interface sm4_rkey_sched_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned RK_W  = 32;
  localparam int unsigned IDX_W = 5;

  // key load request
  logic             key_load_req;
  logic [KEY_W-1:0] key_load_key;
  logic             key_load_ack;

  // key-expansion unit
  logic             kexp_start;
  logic [KEY_W-1:0] kexp_key;
  logic             kexp_key_vld;
  logic [RK_W-1:0]  kexp_rkey;
  logic             kexp_rkey_vld;

  // round core
  logic             core_blk_req;
  logic             core_blk_dec;
  logic             core_blk_gnt;
  logic [RK_W-1:0]  core_rkey;
  logic             core_rkey_vld;
  logic [IDX_W-1:0] core_rkey_idx;

  logic             keys_ready;

  modport master (
    input  key_load_req, key_load_key,
    input  kexp_rkey, kexp_rkey_vld,
    input  core_blk_req, core_blk_dec,
    output key_load_ack,
    output kexp_start, kexp_key, kexp_key_vld,
    output core_blk_gnt, core_rkey, core_rkey_vld, core_rkey_idx,
    output keys_ready
  );

  modport slave (
    output key_load_req, key_load_key,
    output kexp_rkey, kexp_rkey_vld,
    output core_blk_req, core_blk_dec,
    input  key_load_ack,
    input  kexp_start, kexp_key, kexp_key_vld,
    input  core_blk_gnt, core_rkey, core_rkey_vld, core_rkey_idx,
    input  keys_ready
  );
endinterface

// File: rtl/sm4_rkey_sched.sv
// sm4_rkey_sched
// Sits between the SM4 key-expansion unit and the SM4 round core.
// It accepts a user key and starts one expansion. It captures the 32 round
// keys in a local register file. It then streams them one per cycle to the
// core, rk0..rk31 for encryption or rk31..rk0 for decryption. A block never
// runs on a partially expanded key. All outputs are registered.
// Ports:
//   clk_sys : system clock, rising edge
//   sys_rst : synchronous reset, active-high
//   bus     : sm4_rkey_sched_if.master (key load, expansion and core links)
// Build option:
//   SM4_RKEY_SCHED_DEC_EN : when defined, core_blk_dec selects reverse-order
//                           streaming. When undefined, order is always
//                           rk0..rk31.
module sm4_rkey_sched (
  input  logic             clk_sys,
  input  logic             sys_rst,
  sm4_rkey_sched_if.master bus
);
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned RK_W   = 32;
  localparam int unsigned NUM_RK = 32;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY,
    S_STREAM
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cap_cnt_q;
  logic             load_pend_q;
  logic             ack_q;
  logic [KEY_W-1:0] key_q;
  logic             gnt_q;
  logic [RK_W-1:0]  rkey_q;
  logic             rkey_vld_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q;

  // Not reset: contents are only meaningful while ready_q is set.
  logic [RK_W-1:0]  rk_q [NUM_RK];

  logic             last_c;
  logic             load_c;
  logic             accept_c;
  logic             first_c;
  logic             stream_c;
  logic             rk_we_c;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] rd_addr_c;

  // Arbitration between key reload and block streaming.
  // On the last streamed key, a pending or current load beats the core.
  assign last_c   = (state_q == S_STREAM) && (idx_q == IDX_W'(NUM_RK - 1));
  assign load_c   = load_pend_q || bus.key_load_req;
  assign accept_c = ((state_q == S_IDLE)  && bus.key_load_req) ||
                    ((state_q == S_READY) && bus.key_load_req && !bus.core_blk_req) ||
                    (last_c && load_c);
  assign first_c  = ((state_q == S_READY) && bus.core_blk_req) ||
                    (last_c && !load_c && bus.core_blk_req);
  assign stream_c = first_c || ((state_q == S_STREAM) && !last_c);
  assign rk_we_c  = (state_q == S_EXPAND) && bus.kexp_rkey_vld;

  // Round number of the key driven next cycle. 31+1 wraps to 0, so a
  // back-to-back block starts with no bubble.
  assign idx_d = (state_q == S_STREAM) ? idx_q + IDX_W'(1) : '0;

`ifdef SM4_RKEY_SCHED_DEC_EN
  logic dec_q;
  logic dec_d;

  // Direction is taken from the request at grant and held for the whole block.
  assign dec_d     = first_c ? bus.core_blk_dec : dec_q;
  assign rd_addr_c = dec_d ? ~idx_d : idx_d;

  always_ff @(posedge clk_sys) begin
    if (sys_rst) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
    end
  end
`else
  logic unused_dec;

  assign unused_dec = bus.core_blk_dec;
  assign rd_addr_c  = idx_d;
`endif

  // Round-key capture during expansion.
  always_ff @(posedge clk_sys) begin
    if (rk_we_c) begin
      rk_q[cap_cnt_q] <= bus.kexp_rkey;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cap_cnt_q   <= '0;
      load_pend_q <= 1'b0;
      ack_q       <= 1'b0;
      key_q       <= '0;
      gnt_q       <= 1'b0;
      rkey_q      <= '0;
      rkey_vld_q  <= 1'b0;
      idx_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      gnt_q      <= 1'b0;
      rkey_vld_q <= 1'b0;
      rkey_q     <= '0;
      idx_q      <= '0;
      if (accept_c) begin
        state_q     <= S_EXPAND;
        ack_q       <= 1'b1;
        key_q       <= bus.key_load_key;
        ready_q     <= 1'b0;
        cap_cnt_q   <= '0;
        load_pend_q <= 1'b0;
      end else if (stream_c) begin
        state_q    <= S_STREAM;
        gnt_q      <= first_c;
        rkey_vld_q <= 1'b1;
        idx_q      <= idx_d;
        rkey_q     <= rk_q[rd_addr_c];
        // A load seen during a block waits for the block to finish.
        if (bus.key_load_req) begin
          load_pend_q <= 1'b1;
        end
      end else if (rk_we_c) begin
        cap_cnt_q <= cap_cnt_q + IDX_W'(1);
        if (cap_cnt_q == IDX_W'(NUM_RK - 1)) begin
          state_q <= S_READY;
          ready_q <= 1'b1;
        end
      end else if (last_c) begin
        state_q <= S_READY;
      end
    end
  end

  assign bus.key_load_ack  = ack_q;
  assign bus.kexp_start    = ack_q;
  assign bus.kexp_key_vld  = ack_q;
  assign bus.kexp_key      = key_q;
  assign bus.core_blk_gnt  = gnt_q;
  assign bus.core_rkey     = rkey_q;
  assign bus.core_rkey_vld = rkey_vld_q;
  assign bus.core_rkey_idx = idx_q;
  assign bus.keys_ready    = ready_q;

endmodule

// File: tb/tb_sm4_rkey_sched.sv
// tb_sm4_rkey_sched
// Self-checking bench for sm4_rkey_sched. A golden SM4 key-expansion model
// feeds round keys. Expected key streams are queued when a block request is
// driven. A monitor pops and compares them as the DUT streams.
module tb_sm4_rkey_sched;
  typedef logic [31:0][31:0] rkset_t;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] rkey;
    logic        gnt;
  } exp_t;

  localparam logic [127:0] KEY1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY3 = 128'hc0ffee00deadbeef1234567889abcdef;
  localparam logic [127:0] KEY4 = 128'h55aa55aa0f0f0f0ff0f0f0f033cc33cc;

  localparam logic [2047:0] SBOX_P = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic clk;
  logic rst;

  sm4_rkey_sched_if bus ();

  sm4_rkey_sched dut (
    .clk_sys (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int   n_chk;
  int   n_fail;
  int   n_ack;
  int   n_start;
  int   exp_loads;
  int   run_len;
  exp_t sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Golden SM4 key expansion.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    int i;
    i = int'(x);
    return SBOX_P[2047 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] sm4_tp(input logic [31:0] a);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[31-8*j -: 8] = sbox(a[31-8*j -: 8]);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic rkset_t sm4_expand(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] ck;
    logic [31:0] nk;
    rkset_t      rs;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      nk = k[0] ^ sm4_tp(k[1] ^ k[2] ^ k[3] ^ ck);
      rs[i] = nk;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = nk;
    end
    return rs;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the 32 keys one block is expected to stream.
  task automatic push_stream(input rkset_t rs, input bit dec);
    exp_t e;
    bit   d;
`ifdef SM4_RKEY_SCHED_DEC_EN
    d = dec;
`else
    d = 1'b0;
`endif
    for (int k = 0; k < 32; k++) begin
      e.idx  = 5'(k);
      e.rkey = d ? rs[31-k] : rs[k];
      e.gnt  = (k == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"},      bus.key_load_ack,  0);
    chk({tag, "_start"},    bus.kexp_start,    0);
    chk({tag, "_kvld"},     bus.kexp_key_vld,  0);
    chk({tag, "_kkey"},     bus.kexp_key,      0);
    chk({tag, "_gnt"},      bus.core_blk_gnt,  0);
    chk({tag, "_rkey"},     bus.core_rkey,     0);
    chk({tag, "_rvld"},     bus.core_rkey_vld, 0);
    chk({tag, "_idx"},      bus.core_rkey_idx, 0);
    chk({tag, "_ready"},    bus.keys_ready,    0);
  endtask

  // Raise key_load_req and wait for the ack. lat is the number of cycles taken.
  task automatic load_wait_ack(input logic [127:0] key, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    bus.key_load_key = key;
    bus.key_load_req = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (bus.key_load_ack) begin
        got = 1'b1;
        lat = n;
        break;
      end
    end
    exp_loads++;
    chk("ack_seen",    got, 1);
    chk("kexp_start",  bus.kexp_start, 1);
    chk("kexp_key",    bus.kexp_key, key);
    chk("ready_fall",  bus.keys_ready, 0);
    chk("ack_no_vld",  bus.core_rkey_vld, 0);
    bus.key_load_req = 1'b0;
    tick();
    chk("ack_pulse",   bus.key_load_ack, 0);
  endtask

  // Expansion-unit model: feed nfeed golden round keys with gap idle cycles.
  task automatic feed(input logic [127:0] key, input int nfeed, input int gap);
    rkset_t rs;
    rs = sm4_expand(key);
    for (int i = 0; i < nfeed; i++) begin
      bus.kexp_rkey     = rs[i];
      bus.kexp_rkey_vld = 1'b1;
      if (i == 31) chk("ready_before_last", bus.keys_ready, 0);
      tick();
      bus.kexp_rkey_vld = 1'b0;
      bus.kexp_rkey     = '0;
      chk("gnt_in_expand", bus.core_blk_gnt, 0);
      if (i == 31) chk("ready_rise", bus.keys_ready, 1);
      else if (gap > 0) repeat (gap) tick();
    end
  endtask

  // Request one block. The core holds the request until grant, then drops it.
  task automatic core_req_grant(input bit dec, input rkset_t rs, output int lat);
    push_stream(rs, dec);
    bus.core_blk_dec = dec;
    bus.core_blk_req = 1'b1;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (bus.core_blk_gnt) begin
        lat = n;
        break;
      end
    end
    bus.core_blk_req = 1'b0;
    bus.core_blk_dec = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (bus.core_rkey_vld && (bus.core_rkey_idx == 5'(target))) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("reach_idx%0d", target), got, 1);
  endtask

  // Stream monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.key_load_ack) n_ack++;
    if (bus.kexp_start)   n_start++;
    chk("kvld_eq_start", bus.kexp_key_vld, bus.kexp_start);
    if (bus.core_rkey_vld) begin
      run_len++;
      if (sb_q.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("stream_idx",  bus.core_rkey_idx, e.idx);
        chk("stream_rkey", bus.core_rkey,     e.rkey);
        chk("stream_gnt",  bus.core_blk_gnt,  e.gnt);
      end
    end else begin
      if (bus.core_blk_gnt) chk("gnt_without_vld", 1, 0);
      if (run_len != 0) chk("vld_run_mod32", run_len % 32, 0);
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rkset_t rs1;
    rkset_t rs2;
    rkset_t rs3;
    int     lat;

    n_chk = 0; n_fail = 0; n_ack = 0; n_start = 0; exp_loads = 0; run_len = 0;
    rst = 1'b1;
    bus.key_load_req  = 1'b0;
    bus.key_load_key  = '0;
    bus.kexp_rkey     = '0;
    bus.kexp_rkey_vld = 1'b0;
    bus.core_blk_req  = 1'b0;
    bus.core_blk_dec  = 1'b0;
    rs1 = sm4_expand(KEY1);
    rs2 = sm4_expand(KEY2);
    rs3 = sm4_expand(KEY3);

    repeat (3) tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();

    // Core request before any key: held pending until keys are ready.
    push_stream(rs1, 1'b0);
    bus.core_blk_dec = 1'b0;
    bus.core_blk_req = 1'b1;
    repeat (5) begin
      tick();
      chk("gnt_idle", bus.core_blk_gnt, 0);
    end
    load_wait_ack(KEY1, lat);
    feed(KEY1, 32, 0);
    tick();
    chk("gnt_after_ready", bus.core_blk_gnt, 1);
    chk("enc_idx0", bus.core_rkey, 32'hf12186f9);
    bus.core_blk_req = 1'b0;
    wait_idx(31);
    chk("enc_idx31", bus.core_rkey, 32'h9124a012);
    tick();
    chk("enc_vld_fall", bus.core_rkey_vld, 0);

    // Stray round keys outside expansion must not alter the register file.
    bus.kexp_rkey     = 32'hdeadbeef;
    bus.kexp_rkey_vld = 1'b1;
    repeat (2) tick();
    bus.kexp_rkey_vld = 1'b0;
    bus.kexp_rkey     = '0;

    // Decryption-order request.
    core_req_grant(1'b1, rs1, lat);
    chk("dec_gnt_lat", lat, 1);
`ifdef SM4_RKEY_SCHED_DEC_EN
    chk("dec_idx0", bus.core_rkey, 32'h9124a012);
    wait_idx(31);
    chk("dec_idx31", bus.core_rkey, 32'hf12186f9);
`else
    chk("dec_idx0", bus.core_rkey, 32'hf12186f9);
    wait_idx(31);
    chk("dec_idx31", bus.core_rkey, 32'h9124a012);
`endif
    tick();
    chk("dec_vld_fall", bus.core_rkey_vld, 0);

    // Key load arriving mid-stream: stream completes with old keys.
    core_req_grant(1'b0, rs1, lat);
    chk("enc2_gnt_lat", lat, 1);
    wait_idx(10);
    load_wait_ack(KEY2, lat);
    chk("ack_after_idx31", lat, 22);
    feed(KEY2, 32, 1);

    // Simultaneous load and core request in READY: core first, then load.
    push_stream(rs2, 1'b0);
    bus.key_load_key = KEY3;
    bus.key_load_req = 1'b1;
    bus.core_blk_dec = 1'b0;
    bus.core_blk_req = 1'b1;
    tick();
    chk("sim_gnt", bus.core_blk_gnt, 1);
    chk("sim_no_ack", bus.key_load_ack, 0);
    push_stream(rs3, 1'b0);
    wait_idx(31);
    chk("sim_no_ack_idx31", bus.key_load_ack, 0);
    tick();
    exp_loads++;
    chk("sim_ack", bus.key_load_ack, 1);
    chk("sim_kexp_key", bus.kexp_key, KEY3);
    chk("sim_ready_drop", bus.keys_ready, 0);
    chk("sim_no_gnt", bus.core_blk_gnt, 0);
    bus.key_load_req = 1'b0;
    tick();
    chk("sim_ack_pulse", bus.key_load_ack, 0);
    feed(KEY3, 32, 2);
    tick();
    chk("held_gnt", bus.core_blk_gnt, 1);
    bus.core_blk_req = 1'b0;
    wait_idx(31);
    tick();

    // Back-to-back blocks with no bubble. The first block's direction stays latched.
    push_stream(rs3, 1'b0);
    push_stream(rs3, 1'b1);
    bus.core_blk_dec = 1'b0;
    bus.core_blk_req = 1'b1;
    tick();
    chk("b2b_gnt0", bus.core_blk_gnt, 1);
    bus.core_blk_dec = 1'b1;
    wait_idx(31);
    tick();
    chk("b2b_gnt1", bus.core_blk_gnt, 1);
    chk("b2b_idx0", bus.core_rkey_idx, 0);
    chk("b2b_vld", bus.core_rkey_vld, 1);
    bus.core_blk_req = 1'b0;
    bus.core_blk_dec = 1'b0;
    wait_idx(31);
    tick();
    chk("b2b_vld_fall", bus.core_rkey_vld, 0);

    // Reset in the middle of expansion: a full reload is required afterwards.
    load_wait_ack(KEY4, lat);
    feed(KEY4, 17, 0);
    rst = 1'b1;
    tick();
    chk_reset_outs("midrst");
    rst = 1'b0;
    bus.core_blk_req = 1'b1;
    repeat (8) begin
      tick();
      chk("gnt_after_rst", bus.core_blk_gnt, 0);
    end
    push_stream(rs1, 1'b0);
    load_wait_ack(KEY1, lat);
    feed(KEY1, 32, 0);
    tick();
    chk("reload_gnt", bus.core_blk_gnt, 1);
    bus.core_blk_req = 1'b0;
    wait_idx(31);
    repeat (3) tick();

    chk("sb_empty", sb_q.size(), 0);
    chk("ack_count", n_ack, exp_loads);
    chk("start_count", n_start, exp_loads);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_rkey_sched.md
# sm4_rkey_sched

Round-key scheduler between the SM4 key-expansion unit and the SM4 round core. Accepts a 128-bit user key, sequences one key expansion, captures the 32 round keys into a local 32x32 register file, then streams them one per cycle to the core in encryption order (rk0..rk31) or decryption order (rk31..rk0). Arbitrates between key reloads and block requests, so a block never runs on a partially expanded key.

## Interface
- No parameters.
- clk_sys  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- key_load_req  in  1  level; new key request, held until key_load_ack
- key_load_key  in  128  user key, stable while key_load_req=1
- key_load_ack  out  1  one-cycle pulse; key accepted
- kexp_start  out  1  one-cycle start pulse to expansion unit
- kexp_key  out  128  registered copy of accepted key
- kexp_key_vld  out  1  asserted together with kexp_start
- kexp_rkey  in  32  round key from expansion unit
- kexp_rkey_vld  in  1  one pulse per round key, 32 per expansion
- core_blk_req  in  1  level; core requests one block's key stream, held until core_blk_gnt
- core_blk_dec  in  1  1 = decryption order; sampled at grant
- core_blk_gnt  out  1  one-cycle pulse, coincides with first streamed key
- core_rkey  out  32  streamed round key
- core_rkey_vld  out  1  high for 32 consecutive cycles per block
- core_rkey_idx  out  5  core round number 0..31 of current core_rkey
- keys_ready  out  1  register file holds a complete expanded key

## Operation
- States: IDLE (no valid key), EXPAND, READY, STREAM.
- IDLE: key_load_req -> accept; core_blk_req ignored (held pending).
- Accept: next cycle key_load_ack=kexp_start=kexp_key_vld=1 for one cycle, kexp_key=key_load_key, keys_ready=0, capture count=0, state EXPAND.
- EXPAND: each kexp_rkey_vld writes kexp_rkey to rk[count], count+1. On 32nd write -> READY, keys_ready=1 next cycle. New key_load_req and core_blk_req ignored (held) during EXPAND.
- kexp_rkey_vld outside EXPAND ignored; no write.
- READY: core_blk_req -> STREAM. key_load_req alone -> accept as above. Both in the same cycle: core wins, load_pend set.
- STREAM: cycle k (k=0..31) drives core_rkey_idx=k, core_rkey=rk[k] (enc) or rk[31-k] (dec), core_rkey_vld=1; core_blk_gnt=1 at k=0 only. Direction latched at grant.
- key_load_req arriving in STREAM sets load_pend; stream always completes with old keys.
- End of stream (k=31): if load_pend or key_load_req -> accept key next cycle (load beats core). Else if core_blk_req -> next stream starts immediately, no bubble. Else READY.
- Round-key register file not reset; validity carried only by keys_ready.

## Timing
- Reset values: key_load_ack=0, kexp_start=0, kexp_key_vld=0, kexp_key=0, core_blk_gnt=0, core_rkey=0, core_rkey_vld=0, core_rkey_idx=0, keys_ready=0; state IDLE, load_pend=0, counters 0.
- All outputs registered. Request sampled cycle N -> ack or grant at N+1.
- Stream latency: core_blk_req sampled in READY at N -> rkey idx 0 at N+1, idx 31 at N+32.
- keys_ready rises the cycle after the 32nd kexp_rkey_vld and falls in the key_load_ack cycle.
- sys_rst mid-EXPAND or mid-STREAM: abort next edge, all outputs to reset values, keys_ready=0; a new key load is required.

## Configuration
- SM4_RKEY_SCHED_DEC_EN defined: core_blk_dec honoured, reverse-order streaming available.
- Undefined: core_blk_dec ignored, always rk[k] order; reverse-index mux not built.

## Test plan
- Load key 0123456789abcdeffedcba9876543210 with a golden expansion model -> one ack, one kexp_start, keys_ready 1 cycle after 32nd rkey; enc stream idx0=f12186f9, idx31=9124a012.
- Dec request (DEC_EN) -> idx0=9124a012, idx31=f12186f9, gnt only at idx0, vld exactly 32 cycles.
- core_blk_req before any key load -> no grant until keys_ready, then stream starts 1 cycle after the READY sample.
- key_load_req asserted at stream idx 10 -> stream finishes with old keys; ack the cycle after idx31; keys_ready drops.
- Simultaneous key_load_req and core_blk_req in READY -> core granted first, load accepted right after idx31; held core req then waits for new keys.
- sys_rst at EXPAND count 17 -> all outputs 0; subsequent core_blk_req not granted until a full reload.
